// File: rtl/iter_multiplier_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
//   mul_state_t : controller states (IDLE / BUSY / DONE)
//   MUL_WIDTH   : operand width (product is twice this)
//   MUL_STEPS   : shift-add steps per multiply, one per multiplier bit
//   CNT_WIDTH   : width of the step counter
package iter_multiplier_pkg;

    localparam int unsigned MUL_WIDTH = 32;
    localparam int unsigned MUL_STEPS = 32;
    localparam int unsigned CNT_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/iter_multiplier.sv
// Iterative unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier, one
// multiplier bit per clock, used as the multi-cycle multiply unit.
// Ports:
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   in_valid  : start request, sampled only in IDLE
//   mplier    : multiplier operand (unsigned)
//   mcand     : multiplicand operand (unsigned)
//   product   : last completed product, held until the next completion
//   out_valid : one-cycle pulse while in DONE
//   stall     : pipeline hold, high for a pending request or while BUSY
module iter_multiplier
    import iter_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   mplier,
    input  logic [WIDTH-1:0]   mcand,
    output logic [2*WIDTH-1:0] product,
    output logic               out_valid,
    output logic               stall
);

    localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(MUL_STEPS - 1);

    mul_state_t           state;
    mul_state_t           state_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic [WIDTH-1:0]     mcand_q;
    logic [2*WIDTH:0]     acc;
    logic [WIDTH:0]       upper_sum;
    logic [2*WIDTH:0]     acc_step;
    logic                 last_step;

    // One shift-add step: the upper half keeps its carry in acc[2*WIDTH]
    // so the following right shift brings it down into the product range.
    always_comb begin
        if (acc[0]) begin
            upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        end else begin
            upper_sum = acc[2*WIDTH:WIDTH];
        end
        acc_step = {upper_sum, acc[WIDTH-1:0]} >> 1;
    end

    assign last_step = (cnt == LAST_STEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        out_valid  = 1'b0;
        stall      = 1'b0;
        unique case (state)
            IDLE: begin
                stall = in_valid;
                if (in_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            mcand_q <= '0;
            acc     <= '0;
            product <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand_q <= mcand;
                        acc     <= {1'b0, {WIDTH{1'b0}}, mplier};
                        cnt     <= '0;
                    end
                end
                BUSY: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                    if (last_step) begin
                        product <= acc_step[2*WIDTH-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_multiplier.sv
// Self-checking bench for iter_multiplier: expected products and their
// completion cycles are queued when a request is driven and compared when
// out_valid is seen.
module tb_iter_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] mplier;
    logic [31:0] mcand;
    logic [63:0] product;
    logic        out_valid;
    logic        stall;

    iter_multiplier #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .mplier    (mplier),
        .mcand     (mcand),
        .product   (product),
        .out_valid (out_valid),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    // Count of rising edges; at the falling edge after edge k it reads k.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] prod;
        int unsigned due;
    } exp_t;

    exp_t sb[$];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b);
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Scoreboard side: every out_valid must match the head entry, in value
    // and in cycle, and stall must already be low.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("product", product, e.prod);
                check("out_valid_cycle", 64'(cyc), 64'(e.due));
                check("stall_in_done", 64'(stall), 64'd0);
            end
        end
    end

    // Drive one request from a falling edge when the DUT is idle. Acceptance
    // is the next rising edge; out_valid is visible 32 edges later.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit hold);
        @(negedge clk);
        in_valid = 1'b1;
        mplier   = a;
        mcand    = b;
        sb.push_back('{prod: mul64(a, b), due: cyc + 33});
        #1;
        check("stall_on_request", 64'(stall), 64'd1);
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_empty(input int unsigned limit);
        for (int unsigned i = 0; i < limit; i++) begin
            if (sb.size() == 0) return;
            @(negedge clk);
        end
        check("completion_timeout", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int unsigned n;
        rst      = 1'b1;
        in_valid = 1'b1;
        mplier   = '0;
        mcand    = '0;
        repeat (3) @(negedge clk);
        check("reset_stall_follows_in_valid", 64'(stall), 64'd1);
        in_valid = 1'b0;
        #1;
        check("reset_stall_low", 64'(stall), 64'd0);
        check("reset_product", product, 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic request, then idle gap.
        issue(32'd5, 32'd6, 1'b0);
        wait_empty(40);
        repeat (5) @(negedge clk);
        check("product_holds_after_pulse", product, 64'd30);

        // Previous product must hold right up to the new completion edge.
        issue(32'd6, 32'd7, 1'b0);
        repeat (31) @(negedge clk);
        check("product_held_before_completion", product, 64'd30);
        wait_empty(10);

        // Boundary operands.
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_empty(40);
        check("max_product_literal", product, 64'hFFFF_FFFE_0000_0001);
        issue(32'd0, 32'h1234_5678, 1'b0);
        wait_empty(40);
        issue(32'd1, 32'h8000_0000, 1'b0);
        wait_empty(40);
        issue(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
        wait_empty(40);

        // Back-to-back with in_valid held; operands change mid-operation.
        @(negedge clk);
        n = cyc;
        in_valid = 1'b1;
        mplier   = 32'd11;
        mcand    = 32'd13;
        sb.push_back('{prod: 64'd143, due: n + 33});
        sb.push_back('{prod: 64'd323, due: n + 67});
        repeat (3) @(negedge clk);
        mplier = 32'd17;
        mcand  = 32'd19;
        while (cyc < n + 36) @(negedge clk);
        in_valid = 1'b0;
        wait_empty(50);
        repeat (3) @(negedge clk);

        // Reset at BUSY step 10: no pulse, product cleared.
        issue(32'h1234, 32'h55, 1'b0);
        n = cyc;
        while (cyc < n + 10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_product", product, 64'd0);
        check("abort_stall", 64'(stall), 64'd0);
        sb.delete();
        rst = 1'b0;
        repeat (40) @(negedge clk);
        issue(32'd3, 32'd4, 1'b0);
        wait_empty(40);

        // Idle with no request.
        for (int unsigned i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i % 10 == 0) begin
                check("idle_stall", 64'(stall), 64'd0);
                check("idle_out_valid", 64'(out_valid), 64'd0);
            end
        end
        check("idle_product_holds", product, 64'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iter_multiplier.md
# iter_multiplier

Iterative unsigned 32×32→64 shift-add multiplier used as the multi-cycle multiply unit of the processor datapath. It accepts one operand pair per `in_valid` request and spends one clock per multiplier bit. It then pulses `out_valid` with the 64-bit product. While a request is pending or in progress it raises `stall` so the pipeline freezes.

## Interface
- `WIDTH`, default 32, operand width; product is 2·`WIDTH`. Only 32 is required to be supported.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: start request; sampled only in IDLE.
- `mplier` input 32: multiplier operand, unsigned.
- `mcand` input 32: multiplicand operand, unsigned.
- `product` output 64: result register; holds the last completed product.
- `out_valid` output 1: one-cycle pulse, `product` valid.
- `stall` output 1: pipeline hold request.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - If `in_valid`=1 at a rising edge, load `mcand` into the multiplicand register.
  - Load the 65-bit accumulator {1'b0, 32'b0, `mplier`}.
  - Clear the iteration counter, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY, each edge, one step:
  - If accumulator bit 0 = 1, upper 33 bits = {0, acc[63:32]} + mcand (33-bit sum keeps the carry); otherwise unchanged.
  - Shift the whole accumulator right 1 bit.
  - Increment the counter.
  - After the 32nd step, copy acc[63:0] to `product` and go to DONE.
- DONE: `out_valid`=1 for exactly this cycle; next edge goes to IDLE unconditionally.
- `in_valid` is ignored in BUSY and DONE. Operands are captured only at acceptance, so later changes to `mplier`/`mcand` have no effect on the running operation.
- If `in_valid` is still high on return to IDLE, a new multiply starts with the current operands. Holding `in_valid` high therefore gives back-to-back operations.
- Arithmetic is unsigned, modulo nothing: full 64-bit result with no overflow possible.
- `stall` = (IDLE ∧ `in_valid`) ∨ BUSY. It is combinational and low in DONE.
- Reset, from any state including mid-operation:
  - State goes to IDLE; counter, accumulator and `product` go to 0; `out_valid` goes to 0.
  - `stall` follows its equation, so it is 0 unless `in_valid`=1.
  - The aborted operation produces no `out_valid`.

## Timing
- Acceptance edge = E0. Steps occur at E1..E32, and the state becomes DONE at E32.
- `out_valid` is high during the cycle between E32 and E33. `product` becomes valid at E32 and is stable until the next completed operation or reset.
- Latency from the accepting edge to `out_valid` is 32 cycles. Throughput is one multiply per 34 cycles with `in_valid` held high: IDLE re-accepts at E34 (state returns to IDLE at E33).
- `stall` is high from the cycle `in_valid` is presented in IDLE through the last BUSY cycle, and drops in the `out_valid` cycle.
- Reset values: `product`=0, `out_valid`=0, `stall`=`in_valid`.

## Structure
- Shared package holds:
  - the state enum (IDLE/BUSY/DONE),
  - `MUL_WIDTH`=32,
  - `MUL_STEPS`=32,
  - the counter width of 6 bits.
- Single module. No sub-module is required; the 33-bit add may stay inline.
- Registers:
  - state,
  - 6-bit counter,
  - 32-bit multiplicand,
  - 65-bit accumulator,
  - 64-bit `product`.
- `out_valid` is decoded from the DONE state.

## Test plan
- Reset, then `in_valid`=1, `mplier`=5, `mcand`=6 → `stall`=1 immediately. `out_valid` pulses exactly 32 cycles after acceptance with `product`=30. `stall`=0 in that cycle.
- Idle gap, then `mplier`=6, `mcand`=7 → `product`=42. The previous `product`=30 holds until the new completion edge.
- `mplier`=`mcand`=0xFFFFFFFF → `product`=0xFFFFFFFE00000001. Also check 0×0x12345678=0 and 1×0x80000000=0x80000000.
- `in_valid` held high with operands changed mid-operation → the first result uses the captured operands. A new operation starts one cycle after `out_valid`, and pulses are 34 cycles apart.
- Assert `rst` during BUSY, step 10 → the next cycle is IDLE with `product`=0 and no `out_valid` pulse. A subsequent request, 3×4, yields 12.
- `in_valid`=0 throughout → `stall`=0, `out_valid`=0, state remains IDLE.
